serdes_rst_ctrl: RTL and testbench
==================================

// Module: serdes_rst_ctrl
// PURPOSE
// - Reset sequencer for one SERDES lane/quad: PLL reset, wait lock, TX/RX PCS reset, wait reset-done, wait RX CDR lock.
// - Monitors lock after bring-up and re-sequences on loss; bounded retries, then sticky fail.
// - Sits between the board-level reset tree and the SERDES hard block; link_up gates the MAC/PCS datapath.
// PARAMETERS
// - RST_HOLD   16      cycles each reset output is held asserted (>=2)
// - LOCK_TO    65536   cycles allowed for PLL lock before a retry
// - DONE_TO    65536   cycles allowed for tx/rx reset-done (and RX CDR lock) before a retry
// - RETRY_MAX  7       timeouts tolerated; timeout number RETRY_MAX+1 enters FAIL (max 15)
// - CNT_W      20      timer width; must satisfy 2^CNT_W > max(RST_HOLD, LOCK_TO, DONE_TO)
// PORTS
// - clk          in   1   system clock; single clock domain
// - rst          in   1   reset, synchronous, active-high
// - restart      in   1   one-cycle pulse; restarts sequence from S_PLL_RST, clears retry_cnt and fail
// - pll_lock     in   1   SERDES PLL lock, asynchronous to clk
// - tx_rst_done  in   1   TX PCS reset complete, asynchronous
// - rx_rst_done  in   1   RX PCS reset complete, asynchronous
// - rx_cdr_lock  in   1   RX CDR lock, asynchronous
// - pll_rst      out  1   PLL reset to SERDES
// - tx_rst       out  1   TX PCS reset
// - rx_rst       out  1   RX PCS reset
// - link_up      out  1   sequence complete, lane usable
// - fail         out  1   sticky; retries exhausted
// - retry_cnt    out  4   timeouts since last rst/restart, saturating at 15
// BEHAVIOUR
// - All four status inputs pass through 2-flop synchronizers (+2 cycles latency); FSM sees only *_s versions.
// - rst high at a clk edge: state=S_PLL_RST, timer=0, retry_cnt=0; outputs pll_rst=tx_rst=rx_rst=1, link_up=0, fail=0.
// - Timer clears on every state entry, counts +1 per cycle in the state.
// - S_PLL_RST: pll_rst=tx_rst=rx_rst=1; after exactly RST_HOLD cycles -> S_PLL_WAIT.
// - S_PLL_WAIT: pll_rst=0, tx_rst=rx_rst=1; pll_lock_s -> S_PCS_RST; timer==LOCK_TO-1 without lock -> timeout.
// - S_PCS_RST: tx_rst=rx_rst=1 for RST_HOLD cycles -> S_DONE_WAIT.
// - S_DONE_WAIT: tx_rst=rx_rst=0; tx_rst_done_s & rx_rst_done_s & rx_cdr_lock_s -> S_UP; DONE_TO expiry -> timeout.
// - S_UP: link_up=1 (registered, asserts first cycle in S_UP). Checks in priority order:
//   pll_lock_s=0 -> S_PLL_RST; else rx_cdr_lock_s=0 or rx_rst_done_s=0 -> S_RX_RST. No retry increment for loss in S_UP.
// - S_RX_RST: rx_rst=1 only (tx stays out of reset) for RST_HOLD cycles -> S_DONE_WAIT.
// - Timeout: retry_cnt+1 (saturating); if new value > RETRY_MAX -> S_FAIL, else -> S_PLL_RST.
// - S_FAIL: pll_rst=tx_rst=rx_rst=1, link_up=0, fail=1; exits only on rst or restart.
// - Priority: rst > restart > lock loss > success condition > timeout. Success and expiry in the same cycle: success wins.
// - restart in any state (incl. mid-sequence): next state S_PLL_RST, retry_cnt=0, fail=0, link_up=0 next cycle.
// - Leaving S_UP deasserts link_up on the same edge the new reset asserts; no glitch cycle with both.
// - All outputs registered; pll_rst/tx_rst/rx_rst decoded from next-state so they change with state.
// STRUCTURE
// - Package serdes_rst_pkg: state encoding constants (S_PLL_RST, S_PLL_WAIT, S_PCS_RST, S_DONE_WAIT, S_UP, S_RX_RST, S_FAIL), timer width default.
// - One sub-module: serdes_bitsync (2-flop synchronizer, WIDTH param), instanced once with WIDTH=4.
// - Top: FSM, timer, retry counter, output registers.
// TESTING (RST_HOLD=4, LOCK_TO=16, DONE_TO=16, RETRY_MAX=2)
// - Clean bring-up: pll_lock rises 5 cycles after pll_rst falls, done/cdr 3 cycles after tx_rst falls -> pll_rst high 4 cycles, link_up=1, retry_cnt=0.
// - PLL never locks -> timeout every 16+4 cycles, retry_cnt 1,2,3, fail=1 after 3rd timeout, all resets held high.
// - Lock loss in S_UP: drop rx_cdr_lock for 1 cycle -> link_up=0 after 2-cycle sync + 1, rx_rst high 4 cycles, tx_rst stays 0, recovers to S_UP.
// - pll_lock drop in S_UP -> full resequence via S_PLL_RST, retry_cnt unchanged.
// - restart pulse mid S_DONE_WAIT and in S_FAIL -> S_PLL_RST next cycle, fail=0, retry_cnt=0.
// - Done arrives on exact timeout cycle (timer=15) -> S_UP, retry_cnt not incremented; rst mid-sequence -> reset values.

Source files
------------

// File: rtl/serdes_rst_pkg.sv
// Shared state encoding and defaults for the SERDES lane reset sequencer.
package serdes_rst_pkg;

   localparam int CNT_W_DEF = 20;
   localparam int RETRY_W   = 4;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_PLL_WAIT  = 3'd1,
      S_PCS_RST   = 3'd2,
      S_DONE_WAIT = 3'd3,
      S_UP        = 3'd4,
      S_RX_RST    = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   function automatic logic [RETRY_W-1:0] sat_inc(
      input logic [RETRY_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/serdes_bitsync.sv
// Two-flop synchronizer bank for quasi-static status bits from the SERDES.
module serdes_bitsync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         dout <= '0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/serdes_rst_ctrl.sv
// SERDES lane reset sequencer: PLL reset, lock wait, PCS reset, done wait,
// link monitoring with bounded retries and a sticky fail state.
module serdes_rst_ctrl
   import serdes_rst_pkg::*;
#(
   parameter int RST_HOLD  = 16,
   parameter int LOCK_TO   = 65536,
   parameter int DONE_TO   = 65536,
   parameter int RETRY_MAX = 7,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               restart,
   input  logic               pll_lock,
   input  logic               tx_rst_done,
   input  logic               rx_rst_done,
   input  logic               rx_cdr_lock,
   output logic               pll_rst,
   output logic               tx_rst,
   output logic               rx_rst,
   output logic               link_up,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TO - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   timer;
   logic [RETRY_W-1:0] retry_nxt;
   logic               timeout;
   logic               enter;
   logic               pll_rst_nxt;
   logic               tx_rst_nxt;
   logic               rx_rst_nxt;
   logic               link_up_nxt;
   logic               fail_nxt;

   logic [3:0] stat_s;
   logic       pll_lock_s;
   logic       tx_rst_done_s;
   logic       rx_rst_done_s;
   logic       rx_cdr_lock_s;

   serdes_bitsync #(
      .WIDTH (4)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  ({pll_lock, tx_rst_done, rx_rst_done, rx_cdr_lock}),
      .dout (stat_s)
   );

   assign pll_lock_s    = stat_s[3];
   assign tx_rst_done_s = stat_s[2];
   assign rx_rst_done_s = stat_s[1];
   assign rx_cdr_lock_s = stat_s[0];

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      timeout   = 1'b0;
      unique case (state)
         S_PLL_RST: begin
            if (timer == HOLD_LAST)
               state_nxt = S_PLL_WAIT;
         end
         S_PLL_WAIT: begin
            if (pll_lock_s)
               state_nxt = S_PCS_RST;
            else if (timer == LOCK_LAST)
               timeout = 1'b1;
         end
         S_PCS_RST: begin
            if (timer == HOLD_LAST)
               state_nxt = S_DONE_WAIT;
         end
         S_DONE_WAIT: begin
            if (tx_rst_done_s && rx_rst_done_s && rx_cdr_lock_s)
               state_nxt = S_UP;
            else if (timer == DONE_LAST)
               timeout = 1'b1;
         end
         S_UP: begin
            if (!pll_lock_s)
               state_nxt = S_PLL_RST;
            else if (!rx_cdr_lock_s || !rx_rst_done_s)
               state_nxt = S_RX_RST;
         end
         S_RX_RST: begin
            if (timer == HOLD_LAST)
               state_nxt = S_DONE_WAIT;
         end
         S_FAIL: begin
            state_nxt = S_FAIL;
         end
         default: begin
            state_nxt = S_PLL_RST;
         end
      endcase

      if (timeout) begin
         retry_nxt = sat_inc(retry_cnt);
         state_nxt = (retry_nxt > RETRY_LIM) ? S_FAIL : S_PLL_RST;
      end

      if (restart) begin
         state_nxt = S_PLL_RST;
         retry_nxt = '0;
      end

      enter = restart || (state_nxt != state);
   end

   // Outputs decoded from the next state so they move with the state register.
   always_comb begin
      pll_rst_nxt = 1'b1;
      tx_rst_nxt  = 1'b1;
      rx_rst_nxt  = 1'b1;
      link_up_nxt = 1'b0;
      fail_nxt    = 1'b0;
      unique case (state_nxt)
         S_PLL_RST: begin
         end
         S_PLL_WAIT,
         S_PCS_RST: begin
            pll_rst_nxt = 1'b0;
         end
         S_DONE_WAIT: begin
            pll_rst_nxt = 1'b0;
            tx_rst_nxt  = 1'b0;
            rx_rst_nxt  = 1'b0;
         end
         S_UP: begin
            pll_rst_nxt = 1'b0;
            tx_rst_nxt  = 1'b0;
            rx_rst_nxt  = 1'b0;
            link_up_nxt = 1'b1;
         end
         S_RX_RST: begin
            pll_rst_nxt = 1'b0;
            tx_rst_nxt  = 1'b0;
         end
         S_FAIL: begin
            fail_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_PLL_RST;
         timer     <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         tx_rst    <= 1'b1;
         rx_rst    <= 1'b1;
         link_up   <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= state_nxt;
         retry_cnt <= retry_nxt;
         pll_rst   <= pll_rst_nxt;
         tx_rst    <= tx_rst_nxt;
         rx_rst    <= rx_rst_nxt;
         link_up   <= link_up_nxt;
         fail      <= fail_nxt;
         if (enter)
            timer <= '0;
         else if (!(&timer))
            timer <= timer + 1'b1;
      end
   end

endmodule

// File: tb/tb_serdes_rst_ctrl.sv
// Bench for serdes_rst_ctrl: directed boundary cases plus a randomized
// SERDES environment, all checked every cycle against a countdown model.
module tb_serdes_rst_ctrl;

   localparam int RST_HOLD  = 4;
   localparam int LOCK_TO   = 16;
   localparam int DONE_TO   = 16;
   localparam int RETRY_MAX = 2;

   localparam int PH_RST   = 0;
   localparam int PH_PWAIT = 1;
   localparam int PH_PCS   = 2;
   localparam int PH_DWAIT = 3;
   localparam int PH_UP    = 4;
   localparam int PH_RXR   = 5;
   localparam int PH_FAIL  = 6;

   // Expected output level per phase, bit index = phase.
   localparam bit [6:0] T_PLL  = 7'b1000001;
   localparam bit [6:0] T_TX   = 7'b1000111;
   localparam bit [6:0] T_RX   = 7'b1100111;
   localparam bit [6:0] T_UP   = 7'b0010000;
   localparam bit [6:0] T_FAIL = 7'b1000000;

   logic       clk;
   logic       rst;
   logic       restart;
   logic       pll_lock;
   logic       tx_rst_done;
   logic       rx_rst_done;
   logic       rx_cdr_lock;
   logic       pll_rst;
   logic       tx_rst;
   logic       rx_rst;
   logic       link_up;
   logic       fail;
   logic [3:0] retry_cnt;

   serdes_rst_ctrl #(
      .RST_HOLD  (RST_HOLD),
      .LOCK_TO   (LOCK_TO),
      .DONE_TO   (DONE_TO),
      .RETRY_MAX (RETRY_MAX),
      .CNT_W     (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .restart     (restart),
      .pll_lock    (pll_lock),
      .tx_rst_done (tx_rst_done),
      .rx_rst_done (rx_rst_done),
      .rx_cdr_lock (rx_cdr_lock),
      .pll_rst     (pll_rst),
      .tx_rst      (tx_rst),
      .rx_rst      (rx_rst),
      .link_up     (link_up),
      .fail        (fail),
      .retry_cnt   (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Behavioural model: phase plus cycles left before the phase must end.
   int         ph = PH_RST;
   int         left = RST_HOLD;
   int         tries = 0;
   bit         m_valid = 1'b0;
   logic [3:0] m_s1 = '0;
   logic [3:0] m_s2 = '0;

   task automatic enter(input int p);
      ph = p;
      if (p == PH_PWAIT)
         left = LOCK_TO;
      else if (p == PH_DWAIT)
         left = DONE_TO;
      else
         left = RST_HOLD;
   endtask

   task automatic model_step();
      logic [3:0] s;
      bit         to;
      s = m_s2;
      if (rst) begin
         m_s1 = '0;
         m_s2 = '0;
         m_valid = 1'b1;
      end else begin
         m_s2 = m_s1;
         m_s1 = {pll_lock, tx_rst_done, rx_rst_done, rx_cdr_lock};
      end
      if (rst || restart) begin
         tries = 0;
         enter(PH_RST);
         return;
      end
      to = 1'b0;
      if (ph == PH_RST || ph == PH_PCS || ph == PH_RXR) begin
         left--;
         if (left == 0)
            enter(ph == PH_RST ? PH_PWAIT : PH_DWAIT);
      end else if (ph == PH_PWAIT) begin
         if (s[3])
            enter(PH_PCS);
         else begin
            left--;
            to = (left == 0);
         end
      end else if (ph == PH_DWAIT) begin
         if (&s[2:0])
            enter(PH_UP);
         else begin
            left--;
            to = (left == 0);
         end
      end else if (ph == PH_UP) begin
         if (!s[3])
            enter(PH_RST);
         else if (!(s[1] && s[0]))
            enter(PH_RXR);
      end
      if (to) begin
         tries = (tries >= 15) ? 15 : tries + 1;
         enter(tries > RETRY_MAX ? PH_FAIL : PH_RST);
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      if (m_valid) begin
         chk("pll_rst", int'(pll_rst), int'(T_PLL[ph]));
         chk("tx_rst", int'(tx_rst), int'(T_TX[ph]));
         chk("rx_rst", int'(rx_rst), int'(T_RX[ph]));
         chk("link_up", int'(link_up), int'(T_UP[ph]));
         chk("fail", int'(fail), int'(T_FAIL[ph]));
         chk("retry_cnt", int'(retry_cnt), tries);
      end
   end

   // Randomized SERDES environment reacting to the reset outputs.
   bit env_en = 1'b0;
   int pl_cnt = 0, pl_dly = 5, tx_cnt = 0, tx_dly = 3, rx_cnt = 0, rx_dly = 3;
   int pg_left = 0;
   bit pl_b = 0, tx_b = 0, rx_b = 0, cg = 0;

   always @(posedge clk) begin
      #2;
      if (env_en) begin
         restart = ($urandom_range(0, 299) == 0);
         rst     = ($urandom_range(0, 1499) == 0);
         if (pll_rst) begin
            pl_b = 0; pl_cnt = 0; pl_dly = $urandom_range(1, 22);
         end else if (pl_cnt < pl_dly) pl_cnt++;
         else pl_b = 1;
         if (tx_rst) begin
            tx_b = 0; tx_cnt = 0; tx_dly = $urandom_range(1, 18);
         end else if (tx_cnt < tx_dly) tx_cnt++;
         else tx_b = 1;
         if (rx_rst) begin
            rx_b = 0; rx_cnt = 0; rx_dly = $urandom_range(1, 18);
         end else if (rx_cnt < rx_dly) rx_cnt++;
         else rx_b = 1;
         cg = ($urandom_range(0, 149) == 0);
         if (pg_left > 0) pg_left--;
         else if ($urandom_range(0, 399) == 0) pg_left = $urandom_range(1, 3);
         pll_lock    = pl_b && (pg_left == 0);
         tx_rst_done = tx_b;
         rx_rst_done = rx_b;
         rx_cdr_lock = rx_b && !cg;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic do_reset();
      rst = 1'b1; restart = 1'b0; pll_lock = 1'b0;
      tx_rst_done = 1'b0; rx_rst_done = 1'b0; rx_cdr_lock = 1'b0;
      tick();
      rst = 1'b0;
      t = 0;
   endtask

   // Lock appears at t=8, done/cdr at t=dt; observe the resulting timeline.
   task automatic bring(input int dt, output int up_t, output int r31,
                        output int nhi, output int tx_fall);
      do_reset();
      up_t = -1; r31 = -1; nhi = 0; tx_fall = -1;
      for (int i = 0; i < 40; i++) begin
         if (pll_rst) nhi++;
         if (!tx_rst && tx_fall < 0) tx_fall = t;
         if (link_up && up_t < 0) up_t = t;
         if (t == 31) r31 = int'(retry_cnt);
         if (t == 8) pll_lock = 1'b1;
         if (t == dt) begin
            tx_rst_done = 1'b1; rx_rst_done = 1'b1; rx_cdr_lock = 1'b1;
         end
         tick();
      end
   endtask

   initial begin
      int up_t, r31, nhi, tx_fall, rxc, txc, ffail;
      rst = 1'b1; restart = 1'b0; pll_lock = 1'b0;
      tx_rst_done = 1'b0; rx_rst_done = 1'b0; rx_cdr_lock = 1'b0;

      bring(29, up_t, r31, nhi, tx_fall);
      chk("late_done_retry", r31, 1);
      bring(28, up_t, r31, nhi, tx_fall);
      chk("edge_done_up_t", up_t, 31);
      chk("edge_done_retry", r31, 0);
      bring(17, up_t, r31, nhi, tx_fall);
      chk("bringup_up_t", up_t, 20);
      chk("bringup_pll_hi", nhi, 4);
      chk("bringup_tx_fall", tx_fall, 15);
      chk("bringup_retry", int'(retry_cnt), 0);

      rxc = 0; txc = 0;
      for (int i = 0; i < 12; i++) begin
         if (rx_rst) rxc++;
         if (tx_rst) txc++;
         if (i == 3) chk("cdr_drop_link", int'(link_up), 0);
         if (i == 8) chk("cdr_recover_link", int'(link_up), 1);
         if (i == 0) rx_cdr_lock = 1'b0;
         if (i == 1) rx_cdr_lock = 1'b1;
         tick();
      end
      chk("cdr_rx_rst_cycles", rxc, 4);
      chk("cdr_tx_rst_cycles", txc, 0);

      pll_lock = 1'b0;
      tick(); tick();
      chk("pll_drop_link_pre", int'(link_up), 1);
      tick();
      chk("pll_drop_pll_rst", int'(pll_rst), 1);
      chk("pll_drop_link", int'(link_up), 0);
      chk("pll_drop_retry", int'(retry_cnt), 0);

      do_reset();
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_link", int'(link_up), 0);
      ffail = -1;
      for (int i = 0; i < 80; i++) begin
         if (t == 20) chk("nolock_retry1", int'(retry_cnt), 1);
         if (t == 40) chk("nolock_retry2", int'(retry_cnt), 2);
         if (fail && ffail < 0) ffail = t;
         tick();
      end
      chk("nolock_fail_t", ffail, 60);
      chk("nolock_retry3", int'(retry_cnt), 3);
      chk("fail_resets", int'({pll_rst, tx_rst, rx_rst}), 7);

      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("restart_fail", int'(fail), 0);
      chk("restart_retry", int'(retry_cnt), 0);
      chk("restart_pll_rst", int'(pll_rst), 1);

      do_reset();
      for (int i = 0; i < 18; i++) begin
         if (t == 8) pll_lock = 1'b1;
         tick();
      end
      chk("dwait_tx_rst", int'(tx_rst), 0);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("dwait_restart_pll", int'(pll_rst), 1);
      chk("dwait_restart_tx", int'(tx_rst), 1);

      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (t == 8) pll_lock = 1'b1;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_vals", int'({pll_rst, tx_rst, rx_rst, link_up, fail}),
          5'b11100);

      env_en = 1'b1;
      repeat (20000) @(posedge clk);
      env_en = 1'b0;
      #3;
      rst = 1'b0;
      restart = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
